// File: rtl/draw_one_place_send_msg_pkg.sv
// Shared game definitions: map geometry, card codes, message types, FSM states, ctrl payload.
package draw_one_place_send_msg_pkg;

    // Board geometry: 18 columns x 8 rows of 6-bit cells, row-major.
    localparam int unsigned MAP_COLS   = 18;
    localparam int unsigned MAP_ROWS   = 8;
    localparam int unsigned CELL_W     = 6;
    localparam int unsigned MAP_CELLS  = MAP_COLS * MAP_ROWS;
    localparam int unsigned MAP_W      = MAP_CELLS * CELL_W;

    // Tile pile: two decks of 53 codes each.
    localparam int unsigned NUM_TILES  = 106;
    localparam int unsigned DECK_SIZE  = 53;
    localparam int unsigned IDX_W      = 7;

    // Hand area: two rows starting at the first hand row.
    localparam int unsigned HAND_ROWS  = 2;
    localparam int unsigned HAND_CELLS = HAND_ROWS * MAP_COLS;

    // Field widths of the ctrl message.
    localparam int unsigned BLOCK_X_W  = 5;
    localparam int unsigned BLOCK_Y_W  = 3;
    localparam int unsigned MSG_W      = 4;
    localparam int unsigned SEL_LEN_W  = 3;

    // Cell code meaning "no card" and message-type codes.
    localparam logic [CELL_W-1:0] GAME_CARD_EMPTY = 6'd54;
    localparam logic [MSG_W-1:0]  GAME_MSG_NONE   = 4'd0;
    localparam logic [MSG_W-1:0]  GAME_MSG_DRAW   = 4'd3;
    localparam int unsigned       GAME_HAND_Y0    = 6;

    // Draw-and-place controller states.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SEND       = 2'd1,
        ST_WAIT_READY = 2'd2,
        ST_DONE       = 2'd3
    } dps_state_t;

    // Interboard ctrl message payload.
    typedef struct packed {
        logic                  move_dir;
        logic [BLOCK_X_W-1:0]  block_x;
        logic [BLOCK_Y_W-1:0]  block_y;
        logic [MSG_W-1:0]      msg_type;
        logic [CELL_W-1:0]     card;
        logic [SEL_LEN_W-1:0]  sel_len;
    } ctrl_msg_t;

    // Both decks share the same code space: tile i maps to code i mod 53.
    function automatic logic [CELL_W-1:0] tile_to_card(input logic [IDX_W-1:0] idx);
        if (idx < IDX_W'(DECK_SIZE)) begin
            return CELL_W'(idx);
        end
        return CELL_W'(idx - IDX_W'(DECK_SIZE));
    endfunction

endpackage

// File: rtl/draw_one_place_send_msg_first_set.sv
// first_set_106: priority encoder returning the lowest set bit index of a 106-bit vector.
module first_set_106
    import draw_one_place_send_msg_pkg::*;
(
    input  logic [NUM_TILES-1:0] i_vec,
    output logic [IDX_W-1:0]     o_idx_c,
    output logic                 o_valid_c
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        for (int i = NUM_TILES - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx_c   = IDX_W'(i);
                o_valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_one_place_send_msg.sv
// Draw the lowest available tile, pick the first empty hand cell and send one placement message.
module draw_one_place_send_msg
    import draw_one_place_send_msg_pkg::*;
#(
    parameter logic [5:0]  CARD_EMPTY = GAME_CARD_EMPTY,
    parameter logic [3:0]  MSG_DRAW   = GAME_MSG_DRAW,
    parameter int unsigned HAND_Y0    = GAME_HAND_Y0
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  interboard_rst,
    input  logic                  draw_and_place_en,
    input  logic                  inter_ready,
    input  logic [MAP_W-1:0]      map,
    input  logic [NUM_TILES-1:0]  available_card,
    output logic                  draw_and_place_done,
    output logic                  draw_and_place_ready,
    output logic                  draw_place_ctrl_en,
    output logic                  draw_place_ctrl_move_dir,
    output logic [BLOCK_X_W-1:0]  draw_place_ctrl_block_x,
    output logic [BLOCK_Y_W-1:0]  draw_place_ctrl_block_y,
    output logic [MSG_W-1:0]      draw_place_ctrl_msg_type,
    output logic [CELL_W-1:0]     draw_place_ctrl_card,
    output logic [SEL_LEN_W-1:0]  draw_place_ctrl_sel_len
);

    dps_state_t r_state;
    ctrl_msg_t  r_msg;
    logic       r_ctrl_en;
    logic       r_done;
    logic       r_ready;

    logic [NUM_TILES-1:0] w_hand_empty;
    logic [IDX_W-1:0]     w_tile_idx;
    logic                 w_tile_valid;
    logic [IDX_W-1:0]     w_cell_idx;
    logic                 w_cell_valid;
    logic                 w_cell_row1;
    logic [BLOCK_X_W-1:0] w_block_x;
    logic [BLOCK_Y_W-1:0] w_block_y;
    logic [CELL_W-1:0]    w_card;
    logic                 w_map_unused;

    // Only the hand rows feed the cell search; the rest of the board is deliberately ignored.
    assign w_map_unused = ^map;

    // Empty flags for the hand cells in scan order (first hand row, then second), zero padded.
    for (genvar j = 0; j < NUM_TILES; j++) begin : g_hand
        if (j < HAND_CELLS) begin : g_cell
            localparam int unsigned CELL = (HAND_Y0 + j / MAP_COLS) * MAP_COLS + j % MAP_COLS;
            assign w_hand_empty[j] = (map[CELL*CELL_W +: CELL_W] == CARD_EMPTY);
        end else begin : g_pad
            assign w_hand_empty[j] = 1'b0;
        end
    end

    // Lowest available tile.
    first_set_106 u_tile_search (
        .i_vec     (available_card),
        .o_idx_c   (w_tile_idx),
        .o_valid_c (w_tile_valid)
    );

    // First empty hand cell.
    first_set_106 u_cell_search (
        .i_vec     (w_hand_empty),
        .o_idx_c   (w_cell_idx),
        .o_valid_c (w_cell_valid)
    );

    // Hand-cell index to board coordinates.
    assign w_cell_row1 = (w_cell_idx >= IDX_W'(MAP_COLS));
    assign w_block_x   = w_cell_row1 ? BLOCK_X_W'(w_cell_idx - IDX_W'(MAP_COLS))
                                     : BLOCK_X_W'(w_cell_idx);
    assign w_block_y   = BLOCK_Y_W'(HAND_Y0) + {2'b00, w_cell_row1};
    assign w_card      = tile_to_card(w_tile_idx);

    // Controller FSM with registered message fields and pulses.
    always_ff @(posedge clk) begin
        if (rst || interboard_rst) begin
            r_state   <= ST_IDLE;
            r_msg     <= '0;
            r_ctrl_en <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_ctrl_en <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (draw_and_place_en) begin
                        r_ready <= 1'b0;
                        if (w_tile_valid && w_cell_valid) begin
                            r_msg <= '{move_dir: 1'b0,
                                       block_x:  w_block_x,
                                       block_y:  w_block_y,
                                       msg_type: MSG_DRAW,
                                       card:     w_card,
                                       sel_len:  SEL_LEN_W'(1)};
                            r_ctrl_en <= 1'b1;
                            r_state   <= ST_SEND;
                        end else begin
                            // Nothing to place: finish without touching the message.
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_SEND: begin
                    r_state <= ST_WAIT_READY;
                end
                ST_WAIT_READY: begin
                    if (inter_ready) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign draw_and_place_done      = r_done;
    assign draw_and_place_ready     = r_ready;
    assign draw_place_ctrl_en       = r_ctrl_en;
    assign draw_place_ctrl_move_dir = r_msg.move_dir;
    assign draw_place_ctrl_block_x  = r_msg.block_x;
    assign draw_place_ctrl_block_y  = r_msg.block_y;
    assign draw_place_ctrl_msg_type = r_msg.msg_type;
    assign draw_place_ctrl_card     = r_msg.card;
    assign draw_place_ctrl_sel_len  = r_msg.sel_len;

endmodule

// File: tb/tb_draw_one_place_send_msg.sv
// Bench for draw_one_place_send_msg: directed scenarios plus randomized ops vs. a board/pile model.
module tb_draw_one_place_send_msg;

    logic          clk = 1'b0;
    logic          rst;
    logic          interboard_rst;
    logic          draw_and_place_en;
    logic          inter_ready;
    logic [863:0]  map;
    logic [105:0]  available_card;
    logic          draw_and_place_done;
    logic          draw_and_place_ready;
    logic          draw_place_ctrl_en;
    logic          draw_place_ctrl_move_dir;
    logic [4:0]    draw_place_ctrl_block_x;
    logic [2:0]    draw_place_ctrl_block_y;
    logic [3:0]    draw_place_ctrl_msg_type;
    logic [5:0]    draw_place_ctrl_card;
    logic [2:0]    draw_place_ctrl_sel_len;

    // Model of the board and the draw pile.
    logic [5:0]    m_map [144];
    logic [105:0]  m_avail;

    // Expected message fields currently held by the DUT.
    int exp_card, exp_x, exp_y, exp_msg, exp_sel, exp_dir;

    int n_checks = 0;
    int n_fail   = 0;

    draw_one_place_send_msg dut (
        .clk                      (clk),
        .rst                      (rst),
        .interboard_rst           (interboard_rst),
        .draw_and_place_en        (draw_and_place_en),
        .inter_ready              (inter_ready),
        .map                      (map),
        .available_card           (available_card),
        .draw_and_place_done      (draw_and_place_done),
        .draw_and_place_ready     (draw_and_place_ready),
        .draw_place_ctrl_en       (draw_place_ctrl_en),
        .draw_place_ctrl_move_dir (draw_place_ctrl_move_dir),
        .draw_place_ctrl_block_x  (draw_place_ctrl_block_x),
        .draw_place_ctrl_block_y  (draw_place_ctrl_block_y),
        .draw_place_ctrl_msg_type (draw_place_ctrl_msg_type),
        .draw_place_ctrl_card     (draw_place_ctrl_card),
        .draw_place_ctrl_sel_len  (draw_place_ctrl_sel_len)
    );

    always #5 clk = ~clk;

    // Model board drives the DUT map/pile inputs.
    always_comb begin
        map = '0;
        for (int i = 0; i < 144; i++) map[i*6 +: 6] = m_map[i];
    end
    assign available_card = m_avail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fields(input string tag);
        check({tag, "_card"}, 32'(draw_place_ctrl_card),     32'(exp_card));
        check({tag, "_x"},    32'(draw_place_ctrl_block_x),  32'(exp_x));
        check({tag, "_y"},    32'(draw_place_ctrl_block_y),  32'(exp_y));
        check({tag, "_msg"},  32'(draw_place_ctrl_msg_type), 32'(exp_msg));
        check({tag, "_sel"},  32'(draw_place_ctrl_sel_len),  32'(exp_sel));
        check({tag, "_dir"},  32'(draw_place_ctrl_move_dir), 32'(exp_dir));
    endtask

    function automatic int ref_tile();
        for (int i = 0; i < 106; i++) if (m_avail[i]) return i;
        return -1;
    endfunction

    function automatic int ref_cell();
        for (int y = 6; y < 8; y++)
            for (int x = 0; x < 18; x++)
                if (m_map[y*18 + x] == 6'd54) return y*18 + x;
        return -1;
    endfunction

    // One draw-and-place request; delay = cycles inter_ready is held low in WAIT_READY.
    task automatic run_op(input int delay);
        int t;
        int c;
        t = ref_tile();
        c = ref_cell();
        draw_and_place_en = 1'b1;
        inter_ready       = 1'($urandom_range(0, 1));
        step();
        draw_and_place_en = 1'b0;
        if (t >= 0 && c >= 0) begin
            exp_card = (t < 53) ? t : t - 53;
            exp_x    = c % 18;
            exp_y    = c / 18;
            exp_msg  = 3;
            exp_sel  = 1;
            exp_dir  = 0;
            check("send_en",    32'(draw_place_ctrl_en),   32'd1);
            check("send_ready", 32'(draw_and_place_ready), 32'd0);
            check("send_done",  32'(draw_and_place_done),  32'd0);
            check_fields("send");
            // Consumer commits the placement on ctrl_en.
            m_map[c]   = 6'(exp_card);
            m_avail[t] = 1'b0;
            inter_ready = 1'($urandom_range(0, 1));
            step();
            check("wait_en",    32'(draw_place_ctrl_en),   32'd0);
            check("wait_ready", 32'(draw_and_place_ready), 32'd0);
            check("wait_done",  32'(draw_and_place_done),  32'd0);
            for (int i = 0; i < delay; i++) begin
                inter_ready = 1'b0;
                step();
                check("hold_done",  32'(draw_and_place_done),  32'd0);
                check("hold_ready", 32'(draw_and_place_ready), 32'd0);
            end
            inter_ready = 1'b1;
            step();
            check("done_pulse", 32'(draw_and_place_done),  32'd1);
            check("done_ready", 32'(draw_and_place_ready), 32'd0);
            check("done_en",    32'(draw_place_ctrl_en),   32'd0);
            check_fields("done");
        end else begin
            check("skip_en",    32'(draw_place_ctrl_en),   32'd0);
            check("skip_done",  32'(draw_and_place_done),  32'd1);
            check("skip_ready", 32'(draw_and_place_ready), 32'd0);
            check_fields("skip");
        end
        inter_ready = 1'($urandom_range(0, 1));
        step();
        check("end_done",  32'(draw_and_place_done),  32'd0);
        check("end_ready", 32'(draw_and_place_ready), 32'd1);
        check("end_en",    32'(draw_place_ctrl_en),   32'd0);
        check_fields("end");
    endtask

    task automatic fill_board(input int empty_pct);
        for (int i = 0; i < 144; i++)
            m_map[i] = ($urandom_range(0, 99) < empty_pct) ? 6'd54 : 6'($urandom_range(0, 52));
    endtask

    initial begin
        rst               = 1'b1;
        interboard_rst    = 1'b0;
        draw_and_place_en = 1'b0;
        inter_ready       = 1'b0;
        m_avail           = '0;
        for (int i = 0; i < 144; i++) m_map[i] = 6'd54;
        exp_card = 0; exp_x = 0; exp_y = 0; exp_msg = 0; exp_sel = 0; exp_dir = 0;
        step();
        step();
        check("rst_ready", 32'(draw_and_place_ready), 32'd1);
        check("rst_done",  32'(draw_and_place_done),  32'd0);
        check("rst_en",    32'(draw_place_ctrl_en),   32'd0);
        check_fields("rst");

        // Reset wins over a start request in the same cycle.
        m_avail = 106'h3F;
        draw_and_place_en = 1'b1;
        step();
        check("rstprio_en",    32'(draw_place_ctrl_en),   32'd0);
        check("rstprio_ready", 32'(draw_and_place_ready), 32'd1);
        draw_and_place_en = 1'b0;
        rst = 1'b0;
        step();

        // Two hand cells occupied, rest of hand and the upper board empty.
        m_map[108] = 6'd0;
        m_map[109] = 6'd0;
        run_op(0);
        check("d1_card", 32'(draw_place_ctrl_card),    32'd0);
        check("d1_x",    32'(draw_place_ctrl_block_x), 32'd2);
        check("d1_y",    32'(draw_place_ctrl_block_y), 32'd6);
        run_op(0);
        check("d2_card", 32'(draw_place_ctrl_card),    32'd1);
        check("d2_x",    32'(draw_place_ctrl_block_x), 32'd3);
        run_op(5);
        check("d3_card", 32'(draw_place_ctrl_card),    32'd2);
        check("d3_x",    32'(draw_place_ctrl_block_x), 32'd4);

        // Empty pile.
        m_avail = '0;
        run_op(0);

        // Full hand, then a single tile from the second deck.
        for (int i = 108; i < 144; i++) m_map[i] = 6'd10;
        m_avail = 106'h3F;
        run_op(0);
        m_avail = '0;
        m_avail[60] = 1'b1;
        m_map[140] = 6'd54;
        run_op(1);
        check("b60_card", 32'(draw_place_ctrl_card),    32'd7);
        check("b60_x",    32'(draw_place_ctrl_block_x), 32'd14);
        check("b60_y",    32'(draw_place_ctrl_block_y), 32'd7);

        // Interboard reset while waiting for the link.
        m_avail = 106'h1;
        m_map[141] = 6'd54;
        draw_and_place_en = 1'b1;
        inter_ready       = 1'b0;
        step();
        draw_and_place_en = 1'b0;
        check("ibr_send_en", 32'(draw_place_ctrl_en), 32'd1);
        m_map[141] = 6'd0;
        m_avail    = '0;
        step();
        step();
        check("ibr_wait_ready", 32'(draw_and_place_ready), 32'd0);
        interboard_rst = 1'b1;
        inter_ready    = 1'b1;
        step();
        interboard_rst = 1'b0;
        inter_ready    = 1'b0;
        exp_card = 0; exp_x = 0; exp_y = 0; exp_msg = 0; exp_sel = 0; exp_dir = 0;
        check("ibr_ready", 32'(draw_and_place_ready), 32'd1);
        check("ibr_done",  32'(draw_and_place_done),  32'd0);
        check("ibr_en",    32'(draw_place_ctrl_en),   32'd0);
        check_fields("ibr");
        step();
        check("ibr_post_done",  32'(draw_and_place_done),  32'd0);
        check("ibr_post_ready", 32'(draw_and_place_ready), 32'd1);

        // Randomized operations with occasional board/pile regeneration.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) fill_board($urandom_range(0, 30));
            if ($urandom_range(0, 2) == 0) begin
                m_avail = '0;
                if ($urandom_range(0, 5) != 0)
                    for (int i = 0; i < 106; i++) m_avail[i] = ($urandom_range(0, 15) == 0);
            end
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                inter_ready = 1'($urandom_range(0, 1));
                step();
                check("idle_ready", 32'(draw_and_place_ready), 32'd1);
                check("idle_done",  32'(draw_and_place_done),  32'd0);
                check("idle_en",    32'(draw_place_ctrl_en),   32'd0);
            end
            run_op(int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
